// File: rtl/position_counter.sv
// Position transmitter for the serial coincidence comparison: tracks digit and minor cycle
// from the d0 pulse and serialises the short-word position {mc, half} LSB first in two windows.
module position_counter #(
  parameter int DIGITS      = 36,
  parameter int MC_PER_TANK = 16,
  parameter int POS_BITS    = 5,
  parameter int WIN0        = 2,
  parameter int WIN1        = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  d0,
  output logic                  cntr,
  output logic [POS_BITS-1:0]   pos,
  output logic [POS_BITS-2:0]   mc,
  output logic                  tank_start,
  output logic                  synced,
  output logic                  sync_err
);

  localparam int DIG_W = $clog2(DIGITS);
  localparam int MC_W  = POS_BITS - 1;

  localparam logic [DIG_W-1:0] LAST_DIGIT = DIG_W'(DIGITS - 1);
  localparam logic [DIG_W-1:0] W0_LO      = DIG_W'(WIN0);
  localparam logic [DIG_W-1:0] W0_HI      = DIG_W'(WIN0 + POS_BITS - 1);
  localparam logic [DIG_W-1:0] W1_LO      = DIG_W'(WIN1);
  localparam logic [DIG_W-1:0] W1_HI      = DIG_W'(WIN1 + POS_BITS - 1);
  localparam logic [MC_W-1:0]  LAST_MC    = MC_W'(MC_PER_TANK - 1);

  typedef enum logic {UNSYNC, SYNC} state_t;

  state_t            state_q, state_d;
  logic [DIG_W-1:0]  digit_q, digit_d;
  logic [MC_W-1:0]   mc_q, mc_d;
  logic              armed_q;
  logic              in_win0, in_win1;
  logic [DIG_W-1:0]  bit_off;
  logic [POS_BITS-1:0] pos_shift;

  // armed_q blocks a d0 that lands on the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNSYNC;
      digit_q <= '0;
      mc_q    <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      mc_q    <= mc_d;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    digit_d  = digit_q;
    mc_d     = mc_q;
    sync_err = 1'b0;
    case (state_q)
      UNSYNC: begin
        if (d0 && armed_q) begin
          state_d = SYNC;
          digit_d = DIG_W'(1);
          mc_d    = '0;
        end
      end
      SYNC: begin
        if (d0 && (digit_q != '0)) begin
          sync_err = 1'b1;
          digit_d  = DIG_W'(1);
          mc_d     = '0;
        end else if (!d0 && (digit_q == '0)) begin
          sync_err = 1'b1;
          state_d  = UNSYNC;
          mc_d     = '0;
        end else if (digit_q == LAST_DIGIT) begin
          digit_d = '0;
          mc_d    = (mc_q == LAST_MC) ? '0 : mc_q + 1'b1;
        end else begin
          digit_d = digit_q + 1'b1;
        end
      end
      default: state_d = UNSYNC;
    endcase
  end

  // Output decode from registered state only (sync_err above is the one d0-qualified output)
  always_comb begin
    in_win0    = (digit_q >= W0_LO) && (digit_q <= W0_HI);
    in_win1    = (digit_q >= W1_LO) && (digit_q <= W1_HI);
    synced     = (state_q == SYNC);
    mc         = mc_q;
    pos        = {mc_q, (digit_q >= W1_LO)};
    bit_off    = in_win1 ? (digit_q - W1_LO) : (digit_q - W0_LO);
    pos_shift  = pos >> bit_off;
    cntr       = synced && (in_win0 || in_win1) && pos_shift[0];
    tank_start = synced && (digit_q == '0) && (mc_q == '0);
  end

endmodule

// File: tb/tb_position_counter.sv
// Bench for position_counter: per-cycle reference model feeding a scoreboard queue,
// plus directed windows, wrap, early/missing d0 and async reset scenarios.
module tb_position_counter;

  logic       clk;
  logic       rst_n;
  logic       d0;
  logic       cntr;
  logic [4:0] pos;
  logic [3:0] mc;
  logic       tank_start;
  logic       synced;
  logic       sync_err;

  position_counter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d0         (d0),
    .cntr       (cntr),
    .pos        (pos),
    .mc         (mc),
    .tank_start (tank_start),
    .synced     (synced),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       cntr;
    logic [4:0] pos;
    logic       win;
    logic [3:0] mc;
    logic       tank;
    logic       sync;
    logic       err;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  bit m_sync;
  int m_dig;
  int m_mc;
  bit m_armed;

  // last sampled values, for directed captures
  logic last_cntr, last_tank, last_err, last_sync;
  int   last_dig, last_mc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
  endtask

  task automatic model_reset();
    m_sync  = 1'b0;
    m_dig   = 0;
    m_mc    = 0;
    m_armed = 1'b0;
  endtask

  function automatic exp_t model_out(input bit d0v);
    exp_t e;
    int   p;
    int   b;
    p      = m_mc * 2;
    b      = 0;
    e.win  = 1'b0;
    if (m_dig >= 2 && m_dig <= 6) begin
      e.win = 1'b1; b = m_dig - 2;
    end else if (m_dig >= 20 && m_dig <= 24) begin
      e.win = 1'b1; b = m_dig - 20; p = p + 1;
    end
    e.pos  = 5'(p);
    e.cntr = m_sync && e.win && ((p >> b) & 1) == 1;
    e.mc   = 4'(m_mc);
    e.tank = m_sync && m_dig == 0 && m_mc == 0;
    e.sync = m_sync;
    e.err  = m_sync && ((d0v && m_dig != 0) || (!d0v && m_dig == 0));
    return e;
  endfunction

  task automatic model_update(input bit d0v);
    if (!m_sync) begin
      if (d0v && m_armed) begin
        m_sync = 1'b1; m_dig = 1; m_mc = 0;
      end
    end else if (d0v && m_dig != 0) begin
      m_dig = 1; m_mc = 0;
    end else if (!d0v && m_dig == 0) begin
      m_sync = 1'b0; m_mc = 0;
    end else begin
      m_dig = (m_dig + 1) % 36;
      if (m_dig == 0) m_mc = (m_mc + 1) % 16;
    end
    m_armed = 1'b1;
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("cntr", 32'(cntr), 32'(e.cntr));
      check("mc", 32'(mc), 32'(e.mc));
      check("tank_start", 32'(tank_start), 32'(e.tank));
      check("synced", 32'(synced), 32'(e.sync));
      check("sync_err", 32'(sync_err), 32'(e.err));
      if (e.win && e.sync) check("pos", 32'(pos), 32'(e.pos));
    end
  endtask

  task automatic step(input bit d0v);
    @(negedge clk);
    d0 = d0v;
    sb.push_back(model_out(d0v));
    #1;
    last_dig  = m_dig;
    last_mc   = m_mc;
    last_sync = m_sync;
    last_cntr = cntr;
    last_tank = tank_start;
    last_err  = sync_err;
    compare_out();
    @(posedge clk);
    model_update(d0v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int         tanks;
    logic [4:0] c_mc0_w0, c_mc0_w1, c_mc5_w0, c_mc5_w1, c_early_w1;
    logic       any_cntr;

    rst_n = 1'b0;
    d0    = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_cntr", 32'(cntr), 32'd0);
    check("rst_synced", 32'(synced), 32'd0);
    rst_n = 1'b1;

    // idle with no d0
    repeat (100) step(1'b0);
    check("idle_synced", 32'(synced), 32'd0);

    // reset released with d0 on the first edge: d0 ignored
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1);
    step(1'b0);
    check("rel_d0_ignored", 32'(synced), 32'd0);
    repeat (4) step(1'b0);

    // lock, then 16 minor cycles to the wrap
    tanks = 0;
    c_mc0_w0 = 'x; c_mc0_w1 = 'x; c_mc5_w0 = 'x; c_mc5_w1 = 'x;
    for (int k = 0; k <= 576; k++) begin
      step(k % 36 == 0);
      if (last_tank) tanks++;
      if (last_sync && last_dig >= 2 && last_dig <= 6) begin
        if (last_mc == 0) c_mc0_w0[last_dig-2] = last_cntr;
        if (last_mc == 5) c_mc5_w0[last_dig-2] = last_cntr;
      end
      if (last_sync && last_dig >= 20 && last_dig <= 24) begin
        if (last_mc == 0) c_mc0_w1[last_dig-20] = last_cntr;
        if (last_mc == 5) c_mc5_w1[last_dig-20] = last_cntr;
      end
    end
    #1;
    check("tank_once", 32'(tanks), 32'd1);
    check("mc0_win0", 32'(c_mc0_w0), 32'h00);
    check("mc0_win1", 32'(c_mc0_w1), 32'h01);
    check("mc5_win0", 32'(c_mc5_w0), 32'h0A);
    check("mc5_win1", 32'(c_mc5_w1), 32'h0B);
    check("mc_wrapped", 32'(mc), 32'd0);

    // early d0 at digit 17 of mc3
    for (int k = 577; k <= 700; k++) step(k % 36 == 0);
    step(1'b1);
    check("early_err", 32'(last_err), 32'd1);
    check("early_at_mc3", 32'(last_mc), 32'd3);
    #1;
    check("early_mc", 32'(mc), 32'd0);
    c_early_w1 = 'x;
    for (int j = 1; j <= 35; j++) begin
      step(1'b0);
      if (last_dig >= 20 && last_dig <= 24) c_early_w1[last_dig-20] = last_cntr;
    end
    check("early_win1", 32'(c_early_w1), 32'h01);

    // missing d0 at digit 0
    step(1'b0);
    check("miss_err", 32'(last_err), 32'd1);
    any_cntr = 1'b0;
    for (int j = 0; j < 40; j++) begin
      step(1'b0);
      any_cntr = any_cntr | last_cntr;
    end
    check("miss_synced", 32'(synced), 32'd0);
    check("miss_cntr", 32'(any_cntr), 32'd0);
    step(1'b1);
    #1;
    check("relock_synced", 32'(synced), 32'd1);
    check("relock_mc", 32'(mc), 32'd0);

    // async reset mid-window at mc2 digit 22 (cntr=1)
    for (int i = 1; i <= 93; i++) step(i % 36 == 0);
    @(negedge clk);
    d0 = 1'b0;
    #1;
    check("pre_rst_cntr", 32'(cntr), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_cntr", 32'(cntr), 32'd0);
    check("async_synced", 32'(synced), 32'd0);
    check("async_mc", 32'(mc), 32'd0);
    check("async_pos", 32'(pos), 32'd0);
    check("async_tank", 32'(tank_start), 32'd0);
    check("async_err", 32'(sync_err), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) step(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
